crop_bmp_sequencer: RTL

//  Top-level sequencer for the BMP cropping path: validates the crop window, kicks the
//  54-byte header writer, then streams the cropped pixels (B,G,R order, rows bottom-up,

---
 rtl/crop_pkg.sv | 35 +++
 rtl/crop_geom.sv | 76 +++++++
 rtl/crop_bmp_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// ---------------------------------------------------------------------------
// crop_pkg
//   Shared constants, the sequencer state type and the row padding helper for
//   the BMP cropping path.
//   Contents:
//     BMP_HDR_BYTES  size of the BMP file + info header written ahead of pixels
//     BYTES_PER_PX   bytes emitted per pixel (B, G, R)
//     crop_state_t   sequencer state encoding
//     pad_bytes()    zero bytes needed to round a row up to a 4-byte multiple
// ---------------------------------------------------------------------------
package crop_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BYTES_PER_PX  = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CHECK   = 4'd1,
        ST_HDR     = 4'd2,
        ST_RD_REQ  = 4'd3,
        ST_RD_WAIT = 4'd4,
        ST_WR_B    = 4'd5,
        ST_WR_G    = 4'd6,
        ST_WR_R    = 4'd7,
        ST_PAD     = 4'd8,
        ST_FIN     = 4'd9,
        ST_ERR     = 4'd10
    } crop_state_t;

    // (4 - rowBytes mod 4) mod 4, written on the full word so every bit is used.
    function automatic logic [31:0] pad_bytes(input logic [31:0] row_bytes);
        return (32'd4 - row_bytes) & 32'd3;
    endfunction

endpackage

// File: rtl/crop_geom.sv
// ---------------------------------------------------------------------------
// crop_geom
//   Window validation and per-crop geometry for the BMP cropping sequencer.
//   Validity is combinational on the captured window; the geometry words are
//   registered when i_load is high (the sequencer's CHECK cycle) and stay
//   stable for the whole copy.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     i_load            register geometry from the window this cycle
//     i_x_min..i_y_max  captured inclusive crop window (11 bits each)
//     o_valid           window lies inside the source and is non-empty
//     o_row_bytes       3 * (xMax - xMin + 1)
//     o_pad_bytes       zero bytes appended to each output row
//     o_stride          o_row_bytes + o_pad_bytes (output bytes per row)
// ---------------------------------------------------------------------------
module crop_geom
    import crop_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [10:0] i_x_min,
    input  logic [10:0] i_x_max,
    input  logic [10:0] i_y_min,
    input  logic [10:0] i_y_max,
    output logic        o_valid,
    output logic [31:0] o_row_bytes,
    output logic [31:0] o_pad_bytes,
    output logic [31:0] o_stride
);

    logic [31:0] w_x_min;
    logic [31:0] w_x_max;
    logic [31:0] w_y_min;
    logic [31:0] w_y_max;
    logic [31:0] w_cols;
    logic [31:0] w_row_bytes;
    logic [31:0] w_pad_bytes;

    logic [31:0] r_row_bytes;
    logic [31:0] r_pad_bytes;
    logic [31:0] r_stride;

    assign w_x_min = {21'd0, i_x_min};
    assign w_x_max = {21'd0, i_x_max};
    assign w_y_min = {21'd0, i_y_min};
    assign w_y_max = {21'd0, i_y_max};

    assign o_valid = (w_x_min <= w_x_max) && (w_y_min <= w_y_max) &&
                     (w_x_max < WIDTH)    && (w_y_max < HEIGHT);

    // Garbage for an inverted window, but it is never loaded into use then.
    assign w_cols      = w_x_max - w_x_min + 32'd1;
    assign w_row_bytes = w_cols * BYTES_PER_PX;
    assign w_pad_bytes = pad_bytes(w_row_bytes);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_bytes <= '0;
            r_pad_bytes <= '0;
            r_stride    <= '0;
        end else if (i_load) begin
            r_row_bytes <= w_row_bytes;
            r_pad_bytes <= w_pad_bytes;
            r_stride    <= w_row_bytes + w_pad_bytes;
        end
    end

    assign o_row_bytes = r_row_bytes;
    assign o_pad_bytes = r_pad_bytes;
    assign o_stride    = r_stride;

endmodule

// File: rtl/crop_bmp_sequencer.sv
// ---------------------------------------------------------------------------
// crop_bmp_sequencer
//   Top-level sequencer of the BMP cropping path. Validates the crop window,
//   kicks the external 54-byte header writer, then copies the cropped pixels
//   from the source frame buffer into output memory as B,G,R bytes, rows
//   bottom-up, each row zero-padded to a multiple of 4 bytes. The single
//   output write port is shared between the header writer (pass-through
//   while in HDR) and the pixel copy.
//
//   Optional feature: define CROP_BYTE_COUNT_EN to add the bytes_written
//   output, a count of every mem_wren cycle since the last accepted start.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 begin a crop (accepted only in IDLE/FIN/ERR)
//     xMin,xMax,yMin,yMax   inclusive crop window, captured on accepted start
//     busy, done, err       status (done/err are levels held until next start)
//     hdr_start             one-cycle kick to the header writer
//     hdr_done              header writer finished
//     hdr_addr/wren/wrdata  header writer's write port (routed out in HDR)
//     rd_addr, rd_req       source pixel read (addr = y*WIDTH + x)
//     rd_valid, rd_data     source read return, {R,G,B}
//     mem_addr/wren/wrdata  output byte write port
//     bytes_written         (CROP_BYTE_COUNT_EN only) write counter
// ---------------------------------------------------------------------------
module crop_bmp_sequencer
    import crop_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] xMin,
    input  logic [10:0] xMax,
    input  logic [10:0] yMin,
    input  logic [10:0] yMax,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        hdr_start,
    input  logic        hdr_done,
    input  logic [23:0] hdr_addr,
    input  logic        hdr_wren,
    input  logic [15:0] hdr_wrdata,
    output logic [23:0] rd_addr,
    output logic        rd_req,
    input  logic        rd_valid,
    input  logic [23:0] rd_data,
    output logic [23:0] mem_addr,
    output logic        mem_wren,
    output logic [15:0] mem_wrdata
`ifdef CROP_BYTE_COUNT_EN
    ,
    output logic [31:0] bytes_written
`endif
);

    crop_state_t r_state;
    crop_state_t w_state_next;

    // Captured window
    logic [10:0] r_x_min;
    logic [10:0] r_x_max;
    logic [10:0] r_y_min;
    logic [10:0] r_y_max;

    // Copy position
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [31:0] r_row_base;   // output address of the first byte of this row
    logic [31:0] r_col_off;    // 3 * (x - xMin)
    logic [31:0] r_pad_cnt;
    logic [23:0] r_pixel;
    logic        r_hdr_kicked; // already in HDR last cycle, so no new kick

    logic        w_accept;
    logic        w_valid;
    logic [31:0] w_row_bytes;
    logic [31:0] w_pad;
    logic [31:0] w_stride;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_pad_last;
    logic        w_row_end;

    crop_geom #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_geom (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (r_state == ST_CHECK),
        .i_x_min     (r_x_min),
        .i_x_max     (r_x_max),
        .i_y_min     (r_y_min),
        .i_y_max     (r_y_max),
        .o_valid     (w_valid),
        .o_row_bytes (w_row_bytes),
        .o_pad_bytes (w_pad),
        .o_stride    (w_stride)
    );

    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_FIN) ||
                                  (r_state == ST_ERR));
    assign w_last_col = (r_x == r_x_max);
    assign w_last_row = (r_y == r_y_min);
    assign w_pad_last = (r_pad_cnt == w_pad - 32'd1);
    // A row finishes either on its R byte (no padding) or on its last pad byte.
    assign w_row_end  = ((r_state == ST_WR_R) && w_last_col && (w_pad == 32'd0)) ||
                        ((r_state == ST_PAD) && w_pad_last);

    assign rd_addr = 24'(r_y) * 24'(WIDTH) + 24'(r_x);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        hdr_start    = 1'b0;
        rd_req       = 1'b0;
        mem_addr     = '0;
        mem_wren     = 1'b0;
        mem_wrdata   = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_CHECK;
            end
            ST_FIN: begin
                done = 1'b1;
                if (start) w_state_next = ST_CHECK;
            end
            ST_ERR: begin
                err = 1'b1;
                if (start) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                busy         = 1'b1;
                w_state_next = w_valid ? ST_HDR : ST_ERR;
            end
            ST_HDR: begin
                busy       = 1'b1;
                hdr_start  = !r_hdr_kicked;
                mem_addr   = hdr_addr;
                mem_wren   = hdr_wren;
                mem_wrdata = hdr_wrdata;
                if (hdr_done) w_state_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                busy         = 1'b1;
                rd_req       = 1'b1;
                w_state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                busy = 1'b1;
                if (rd_valid) w_state_next = ST_WR_B;
            end
            ST_WR_B: begin
                busy         = 1'b1;
                mem_addr     = 24'(r_row_base + r_col_off);
                mem_wren     = 1'b1;
                mem_wrdata   = {8'h00, r_pixel[7:0]};
                w_state_next = ST_WR_G;
            end
            ST_WR_G: begin
                busy         = 1'b1;
                mem_addr     = 24'(r_row_base + r_col_off + 32'd1);
                mem_wren     = 1'b1;
                mem_wrdata   = {8'h00, r_pixel[15:8]};
                w_state_next = ST_WR_R;
            end
            ST_WR_R: begin
                busy       = 1'b1;
                mem_addr   = 24'(r_row_base + r_col_off + 32'd2);
                mem_wren   = 1'b1;
                mem_wrdata = {8'h00, r_pixel[23:16]};
                if (!w_last_col) begin
                    w_state_next = ST_RD_REQ;
                end else if (w_pad != 32'd0) begin
                    w_state_next = ST_PAD;
                end else begin
                    w_state_next = w_last_row ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_PAD: begin
                busy       = 1'b1;
                mem_addr   = 24'(r_row_base + w_row_bytes + r_pad_cnt);
                mem_wren   = 1'b1;
                mem_wrdata = '0;
                if (w_pad_last) w_state_next = w_last_row ? ST_FIN : ST_RD_REQ;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Window capture and copy datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_min      <= '0;
            r_x_max      <= '0;
            r_y_min      <= '0;
            r_y_max      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_row_base   <= '0;
            r_col_off    <= '0;
            r_pad_cnt    <= '0;
            r_pixel      <= '0;
            r_hdr_kicked <= 1'b0;
        end else begin
            r_hdr_kicked <= (r_state == ST_HDR);

            if (w_accept) begin
                r_x_min <= xMin;
                r_x_max <= xMax;
                r_y_min <= yMin;
                r_y_max <= yMax;
            end

            // Start at the bottom row of the window (BMP rows run bottom-up).
            if (r_state == ST_CHECK) begin
                r_x        <= r_x_min;
                r_y        <= r_y_max;
                r_row_base <= 32'(BMP_HDR_BYTES);
                r_col_off  <= '0;
                r_pad_cnt  <= '0;
            end

            if ((r_state == ST_RD_WAIT) && rd_valid) begin
                r_pixel <= rd_data;
            end

            if ((r_state == ST_WR_R) && !w_last_col) begin
                r_x       <= r_x + 11'd1;
                r_col_off <= r_col_off + 32'(BYTES_PER_PX);
            end

            if (r_state == ST_PAD) begin
                r_pad_cnt <= r_pad_cnt + 32'd1;
            end

            if (w_row_end) begin
                r_pad_cnt <= '0;
                if (!w_last_row) begin
                    r_y        <= r_y - 11'd1;
                    r_x        <= r_x_min;
                    r_col_off  <= '0;
                    r_row_base <= r_row_base + w_stride;
                end
            end
        end
    end

`ifdef CROP_BYTE_COUNT_EN
    logic [31:0] r_bytes_written;

    // Accepted starts only happen in IDLE/FIN/ERR, where mem_wren is low,
    // so clearing takes priority without losing a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bytes_written <= '0;
        end else if (w_accept) begin
            r_bytes_written <= '0;
        end else if (mem_wren) begin
            r_bytes_written <= r_bytes_written + 32'd1;
        end
    end

    assign bytes_written = r_bytes_written;
`endif

endmodule
